// File: rtl/gray_window_3x3.sv
// gray_window_3x3
//   Converts a 24-bit RGB pixel stream to 8-bit luma, keeps the two previous
//   lines in on-chip line buffers and emits a registered 3x3 luma window
//   (top-left in win[71:64], newest pixel in win[7:0]) with a valid strobe.
//   Pipeline: E0 position/capture, E1 luma, E2 line buffers + window shift,
//   E3 output register.
//   Optional build macro GRAY_WINDOW_LUMA_AVG_EN selects the multiplier-free
//   luma Y = (R + 2G + B) >> 2 instead of (77R + 150G + 29B) >> 8.
module gray_window_3x3 #(
  parameter int WIDTH = 640,
  parameter int COL_W = 10,
  parameter int ROW_W = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [23:0]      rgb_in,
  input  logic             pix_valid,
  input  logic             line_start,
  input  logic             frame_start,
  output logic [71:0]      win,
  output logic             win_valid,
  output logic [COL_W-1:0] win_col,
  output logic [ROW_W-1:0] win_row
);

  localparam int               ADDR_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [COL_W-1:0] COL_END = COL_W'(WIDTH);
  localparam logic [ROW_W-1:0] ROW_MAX = '1;
  localparam logic [COL_W-1:0] COL_TWO = COL_W'(2);
  localparam logic [ROW_W-1:0] ROW_TWO = ROW_W'(2);

  // Position tracking
  logic             in_frame_q, in_frame_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             accept;

  // Stage 0: captured pixel and its position
  logic             s0_valid_q, s0_valid_d;
  logic [23:0]      s0_rgb_q, s0_rgb_d;
  logic [COL_W-1:0] s0_col_q, s0_col_d;
  logic [ROW_W-1:0] s0_row_q, s0_row_d;

  // Stage 1: luma
  logic [7:0]       luma_y;
  logic             s1_valid_q, s1_valid_d;
  logic [7:0]       s1_y_q, s1_y_d;
  logic [COL_W-1:0] s1_col_q, s1_col_d;
  logic [ROW_W-1:0] s1_row_q, s1_row_d;

  // Stage 2: line buffers and 3-column window, each column {row-2, row-1, row}
  logic [7:0]       lb0_mem [WIDTH];
  logic [7:0]       lb1_mem [WIDTH];
  logic [ADDR_W-1:0] lb_addr;
  logic [7:0]       lb0_rd, lb1_rd;
  logic [23:0]      wc0_q, wc0_d;
  logic [23:0]      wc1_q, wc1_d;
  logic [23:0]      wc2_q, wc2_d;
  logic             s2_valid_q, s2_valid_d;
  logic [COL_W-1:0] s2_col_q, s2_col_d;
  logic [ROW_W-1:0] s2_row_q, s2_row_d;

  // Stage 3: outputs
  logic [71:0]      win_q, win_d;
  logic             win_valid_q, win_valid_d;
  logic [COL_W-1:0] win_col_q, win_col_d;
  logic [ROW_W-1:0] win_row_q, win_row_d;

  // Next position of the incoming pixel; unframed pixels and overlong columns are dropped
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    in_frame_d = in_frame_q;
    col_d      = col_q;
    row_d      = row_q;
    if (pix_valid) begin
      if (frame_start) begin
        in_frame_d = 1'b1;
        col_d      = '0;
        row_d      = '0;
      end else if (in_frame_q) begin
        if (line_start) begin
          col_d = '0;
          row_d = (row_q == ROW_MAX) ? row_q : row_q + 1'b1;
        end else begin
          col_d = (col_q >= COL_END) ? COL_END : col_q + 1'b1;
        end
      end
    end
    accept = pix_valid && (frame_start || in_frame_q) && (col_d < COL_END);
  end

  // Luma conversion of the stage-0 pixel
`ifdef GRAY_WINDOW_LUMA_AVG_EN
  logic [9:0] y_sum;
  always_comb begin
    y_sum  = {2'b00, s0_rgb_q[23:16]} + {1'b0, s0_rgb_q[15:8], 1'b0} + {2'b00, s0_rgb_q[7:0]};
    luma_y = 8'(y_sum >> 2);
  end
`else
  logic [15:0] y_sum;
  always_comb begin
    y_sum  = 16'd77  * {8'h00, s0_rgb_q[23:16]}
           + 16'd150 * {8'h00, s0_rgb_q[15:8]}
           + 16'd29  * {8'h00, s0_rgb_q[7:0]};
    luma_y = 8'(y_sum >> 8);
  end
`endif

  // Stage 0 capture and stage 1 luma register inputs
  always_comb begin
    s0_valid_d = accept;
    s0_rgb_d   = rgb_in;
    s0_col_d   = col_d;
    s0_row_d   = row_d;
    s1_valid_d = s0_valid_q;
    s1_y_d     = luma_y;
    s1_col_d   = s0_col_q;
    s1_row_d   = s0_row_q;
  end

  // Old line-buffer contents at the current column (read-before-write)
  always_comb begin
    lb_addr = s1_col_q[ADDR_W-1:0];
    lb0_rd  = lb0_mem[lb_addr];
    lb1_rd  = lb1_mem[lb_addr];
  end

  // Shift the new column into the window and apply the row/column gate
  always_comb begin
    wc0_d = wc0_q;
    wc1_d = wc1_q;
    wc2_d = wc2_q;
    if (s1_valid_q) begin
      wc0_d = wc1_q;
      wc1_d = wc2_q;
      wc2_d = {lb1_rd, lb0_rd, s1_y_q};
    end
    s2_valid_d = s1_valid_q && (s1_row_q >= ROW_TWO) && (s1_col_q >= COL_TWO);
    s2_col_d   = s1_col_q;
    s2_row_d   = s1_row_q;
  end

  // Output register; contents hold between windows
  always_comb begin
    win_d       = win_q;
    win_col_d   = win_col_q;
    win_row_d   = win_row_q;
    win_valid_d = s2_valid_q;
    if (s2_valid_q) begin
      win_d     = {wc0_q[23:16], wc1_q[23:16], wc2_q[23:16],
                   wc0_q[15:8],  wc1_q[15:8],  wc2_q[15:8],
                   wc0_q[7:0],   wc1_q[7:0],   wc2_q[7:0]};
      win_col_d = s2_col_q;
      win_row_d = s2_row_q;
    end
  end

  // Line-buffer write: row-1 moves to row-2, the new luma becomes row-1
  // NOTE: the line buffers are deliberately not reset; the row gate keeps stale contents out of win.
  always_ff @(posedge clk) begin
    if (s1_valid_q) begin
      lb1_mem[lb_addr] <= lb0_rd;
      lb0_mem[lb_addr] <= s1_y_q;
    end
  end

  // Pipeline and control registers with synchronous reset
  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_frame_q  <= 1'b0;
      col_q       <= '0;
      row_q       <= '0;
      s0_valid_q  <= 1'b0;
      s0_rgb_q    <= '0;
      s0_col_q    <= '0;
      s0_row_q    <= '0;
      s1_valid_q  <= 1'b0;
      s1_y_q      <= '0;
      s1_col_q    <= '0;
      s1_row_q    <= '0;
      wc0_q       <= '0;
      wc1_q       <= '0;
      wc2_q       <= '0;
      s2_valid_q  <= 1'b0;
      s2_col_q    <= '0;
      s2_row_q    <= '0;
      win_q       <= '0;
      win_valid_q <= 1'b0;
      win_col_q   <= '0;
      win_row_q   <= '0;
    end else begin
      in_frame_q  <= in_frame_d;
      col_q       <= col_d;
      row_q       <= row_d;
      s0_valid_q  <= s0_valid_d;
      s0_rgb_q    <= s0_rgb_d;
      s0_col_q    <= s0_col_d;
      s0_row_q    <= s0_row_d;
      s1_valid_q  <= s1_valid_d;
      s1_y_q      <= s1_y_d;
      s1_col_q    <= s1_col_d;
      s1_row_q    <= s1_row_d;
      wc0_q       <= wc0_d;
      wc1_q       <= wc1_d;
      wc2_q       <= wc2_d;
      s2_valid_q  <= s2_valid_d;
      s2_col_q    <= s2_col_d;
      s2_row_q    <= s2_row_d;
      win_q       <= win_d;
      win_valid_q <= win_valid_d;
      win_col_q   <= win_col_d;
      win_row_q   <= win_row_d;
    end
  end

  assign win       = win_q;
  assign win_valid = win_valid_q;
  assign win_col   = win_col_q;
  assign win_row   = win_row_q;

endmodule
